// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// 32-step shift-add unsigned multiply sequenced through the ALU's ADD op.

module ALU (
    input  logic [3:0]  i_op,
    input  logic [31:0] i_d1,
    input  logic [31:0] i_d2,
    output logic [31:0] o_result
);
    always_comb begin
        case (i_op)
            4'd0:    o_result = i_d1;
            4'd1:    o_result = i_d1 + i_d2;
            4'd2:    o_result = i_d1 - i_d2;
            default: o_result = '0;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid_0,
    input  logic        i_req_valid_1,
    output logic        o_req_ready_0,
    output logic        o_req_ready_1,
    input  logic [3:0]  i_req_op_0,
    input  logic [3:0]  i_req_op_1,
    input  logic [31:0] i_req_d1_0,
    input  logic [31:0] i_req_d2_0,
    input  logic [31:0] i_req_d1_1,
    input  logic [31:0] i_req_d2_1,
    output logic        o_rsp_valid_0,
    output logic        o_rsp_valid_1,
    input  logic        i_rsp_ready_0,
    input  logic        i_rsp_ready_1,
    output logic [31:0] o_rsp_result,
    output logic        o_rsp_error,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd3;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        owner_q, owner_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        error_q, error_d;

    logic        grant_0, grant_1;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;

    ALU u_alu (
        .i_op     (alu_op),
        .i_d1     (alu_a),
        .i_d2     (alu_b),
        .o_result (alu_y)
    );

    always_comb begin
        grant_0       = i_req_valid_0 && (!i_req_valid_1 || !rr_q);
        grant_1       = i_req_valid_1 && (!i_req_valid_0 || rr_q);
        o_req_ready_0 = (state_q == S_IDLE) && grant_0 && i_reset_n;
        o_req_ready_1 = (state_q == S_IDLE) && grant_1 && i_reset_n;
        o_rsp_valid_0 = (state_q == S_RESP) && !owner_q;
        o_rsp_valid_1 = (state_q == S_RESP) && owner_q;
        o_rsp_result  = result_q;
        o_rsp_error   = error_q;
        o_busy        = (state_q != S_IDLE);
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        error_d  = error_q;
        alu_op   = OP_PASS;
        alu_a    = d1_q;
        alu_b    = d2_q;
        case (state_q)
            S_IDLE: begin
                if (o_req_ready_0 || o_req_ready_1) begin
                    owner_d = o_req_ready_1;
                    rr_d    = !o_req_ready_1;
                    op_d    = o_req_ready_1 ? i_req_op_1 : i_req_op_0;
                    d1_d    = o_req_ready_1 ? i_req_d1_1 : i_req_d1_0;
                    d2_d    = o_req_ready_1 ? i_req_d2_1 : i_req_d2_0;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = (op_d == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op   = op_q;
                result_d = alu_y;
                error_d  = (op_q > OP_MUL);
                state_d  = S_RESP;
            end
            S_MUL: begin
                // d1_q/d2_q double as multiplicand/multiplier shift registers
                alu_op  = OP_ADD;
                alu_a   = acc_q;
                alu_b   = d1_q;
                if (d2_q[0]) begin
                    acc_d = alu_y;
                end
                d1_d    = d1_q << 1;
                d2_d    = d2_q >> 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = d2_q[0] ? alu_y : acc_q;
                    error_d  = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_q ? i_rsp_ready_1 : i_rsp_ready_0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every
// cycle, directed literal cases, round-robin/backpressure/reset scenarios.

`timescale 1ns/1ps
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        rv0, rv1, rr0_i, rr1_i;
    logic [31:0] res;
    logic        err, busy;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req_valid_0 (v0),
        .i_req_valid_1 (v1),
        .o_req_ready_0 (r0),
        .o_req_ready_1 (r1),
        .i_req_op_0    (op0),
        .i_req_op_1    (op1),
        .i_req_d1_0    (a0),
        .i_req_d2_0    (b0),
        .i_req_d1_1    (a1),
        .i_req_d2_1    (b1),
        .o_rsp_valid_0 (rv0),
        .o_rsp_valid_1 (rv1),
        .i_rsp_ready_0 (rr0_i),
        .i_rsp_ready_1 (rr1_i),
        .o_rsp_result  (res),
        .o_rsp_error   (err),
        .o_busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {error, result} from the arithmetic meaning of each op code
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        case (op)
            4'd0: return {1'b0, x};
            4'd1: return {1'b0, x + y};
            4'd2: return {1'b0, x - y};
            4'd3: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p[31:0]};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    bit          m_busy = 0, m_rr = 0, m_owner = 0;
    logic [31:0] m_res;
    logic        m_err;
    int unsigned m_due;
    logic        e0, e1;
    logic [32:0] mr;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0;
                m_rr   = 0;
                chk("rst_req_ready", {30'd0, r1, r0}, 32'd0);
                chk("rst_rsp_valid", {30'd0, rv1, rv0}, 32'd0);
                chk("rst_busy", busy, 0);
                chk("rst_result", res, 0);
                chk("rst_error", err, 0);
            end else if (!m_busy) begin
                e0 = v0 && (!v1 || !m_rr);
                e1 = v1 && (!v0 || m_rr);
                chk("idle_req_ready", {30'd0, r1, r0}, {30'd0, e1, e0});
                chk("idle_busy", busy, 0);
                chk("idle_rsp_valid", {30'd0, rv1, rv0}, 32'd0);
                if (e0 || e1) begin
                    m_busy  = 1;
                    m_owner = e1;
                    m_rr    = !e1;
                    mr      = e1 ? model(op1, a1, b1) : model(op0, a0, b0);
                    m_res   = mr[31:0];
                    m_err   = mr[32];
                    m_due   = cyc + (((e1 ? op1 : op0) == 4'd3) ? 33 : 2);
                end
            end else begin
                chk("busy_req_ready", {30'd0, r1, r0}, 32'd0);
                chk("busy_flag", busy, 1);
                if (cyc < m_due) begin
                    chk("early_rsp_valid", {30'd0, rv1, rv0}, 32'd0);
                end else begin
                    chk("rsp_valid", {30'd0, rv1, rv0}, m_owner ? 32'd2 : 32'd1);
                    chk("rsp_result", res, m_res);
                    chk("rsp_error", err, m_err);
                    if (m_owner ? rr1_i : rr0_i) m_busy = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bit idle;
        idle = 0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        chk(name, idle, 1);
        step();
    endtask

    task automatic wait_ready(input bit who, input string name, output int unsigned hs, output bit got);
        got = 0;
        hs  = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (who ? r1 : r0) begin
                got = 1;
                hs  = cyc;
            end
        end
        chk(name, got, 1);
    endtask

    task automatic directed(input bit who, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_r, input logic exp_e, input int unsigned exp_lat,
                            input string name);
        int unsigned hs;
        bit          got;
        if (who) begin v1 = 1; op1 = op; a1 = x; b1 = y; end
        else     begin v0 = 1; op0 = op; a0 = x; b0 = y; end
        wait_ready(who, {name, "_accept"}, hs, got);
        step();
        v0 = 0;
        v1 = 0;
        if (got) begin
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (rv0 || rv1) got = 1;
            end
            chk({name, "_rsp_seen"}, got, 1);
            if (got) begin
                chk({name, "_latency"}, cyc - hs, exp_lat);
                chk({name, "_owner"}, {30'd0, rv1, rv0}, who ? 32'd2 : 32'd1);
                chk({name, "_result"}, res, exp_r);
                chk({name, "_error"}, err, exp_e);
            end
            step();
        end
    endtask

    task automatic rand_req(output logic [3:0] op, output logic [31:0] x, output logic [31:0] y);
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 10)      op = 4'(r % 3);
        else if (r < 12) op = 4'd3;
        else             op = 4'($urandom_range(4, 15));
        case ($urandom_range(0, 5))
            0:       x = 32'h0;
            1:       x = 32'hFFFFFFFF;
            2:       x = 32'h80000000;
            default: x = $urandom;
        endcase
        y = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        bit          got, h0, h1, g, pg;
        int          n;
        rst_n = 0;
        v0 = 0; v1 = 0; op0 = 0; op1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        rr0_i = 0; rr1_i = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        rr0_i = 1;
        rr1_i = 1;

        directed(0, 4'd1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 2,  "add_ovf");
        directed(0, 4'd2, 32'h0,        32'h1,        32'hFFFFFFFF, 0, 2,  "sub_wrap");
        directed(1, 4'd0, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 0, 2,  "pass");
        directed(0, 4'd3, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0, 33, "mul_a");
        directed(1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 33, "mul_b");
        directed(0, 4'd3, 32'hCAFEBABE, 32'h0,        32'h0,        0, 33, "mul_zero");
        directed(1, 4'd9, 32'h5,        32'h7,        32'h0,        1, 2,  "unsupported");

        // last grant went to requester 1, so the pointer now favours 0
        v0 = 1; op0 = 4'd1; a0 = 32'd10; b0 = 32'd1;
        v1 = 1; op1 = 4'd1; a1 = 32'd20; b1 = 32'd2;
        n = 0;
        pg = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (r0 || r1) begin
                g = r1;
                chk("rr_grant_seq", g, 32'(n % 2));
                if (n > 0) chk("rr_alternate", g, !pg);
                pg = g;
                n++;
            end
        end
        chk("rr_grant_count", n, 4);
        step();
        v0 = 0;
        v1 = 0;
        drain("rr_drain");

        rr0_i = 0;
        v0 = 1; op0 = 4'd1; a0 = 32'd3; b0 = 32'd4;
        v1 = 1; op1 = 4'd2; a1 = 32'd9; b1 = 32'd1;
        wait_ready(0, "bp_accept", hs, got);
        step();
        v0 = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rv0) got = 1;
        end
        chk("bp_rsp_seen", got, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", rv0, 1);
            chk("bp_result_hold", res, 32'd7);
            chk("bp_other_ready", r1, 0);
        end
        step();
        rr0_i = 1;
        wait_ready(1, "bp_next_grant", hs, got);
        step();
        v1 = 0;
        drain("bp_drain");

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            h0 = v0 && r0;
            h1 = v1 && r1;
            step();
            if (h0 || !v0) begin
                if ($urandom_range(0, 3) == 0) begin v0 = 1; rand_req(op0, a0, b0); end
                else v0 = 0;
            end else if ($urandom_range(0, 19) == 0) v0 = 0;
            if (h1 || !v1) begin
                if ($urandom_range(0, 3) == 0) begin v1 = 1; rand_req(op1, a1, b1); end
                else v1 = 0;
            end else if ($urandom_range(0, 19) == 0) v1 = 0;
            rr0_i = ($urandom_range(0, 3) != 0);
            rr1_i = ($urandom_range(0, 3) != 0);
        end
        v0 = 0;
        v1 = 0;
        rr0_i = 1;
        rr1_i = 1;
        drain("rand_drain");

        directed(1, 4'd0, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 0, 2, "pre_reset");
        v0 = 1; op0 = 4'd3; a0 = 32'h00012345; b0 = 32'h00000777;
        wait_ready(0, "mid_rst_accept", hs, got);
        step();
        v0 = 0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_req_ready", {30'd0, r1, r0}, 32'd0);
        chk("async_rst_rsp_valid", {30'd0, rv1, rv0}, 32'd0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_result", res, 0);
        chk("async_rst_error", err, 0);
        step();
        rst_n = 1;
        v0 = 1; op0 = 4'd0; a0 = 32'hA5A5A5A5; b0 = 32'h1;
        v1 = 1; op1 = 4'd0; a1 = 32'h5A5A5A5A; b1 = 32'h2;
        @(negedge clk);
        chk("post_rst_rr_ready", {30'd0, r1, r0}, 32'd1);
        step();
        v0 = 0;
        v1 = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rv0 || rv1) got = 1;
        end
        chk("post_rst_rsp_seen", got, 1);
        chk("post_rst_owner", {30'd0, rv1, rv0}, 32'd1);
        chk("post_rst_result", res, 32'hA5A5A5A5);
        step();
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
